seg_rx: RTL and testbench

Seven-segment capture/decoder: the receive end of the multiplexed display bus. It samples the active-high segment bus and the active-low digit enables d1..d4 driven by the display encoder. It waits for each pattern to be stable, decodes each glyph back into a hex nibble, and reconstructs the 4-digit value with per-digit valid and error flags. It is used for on-board loopback self-test and for bench observation of display drivers.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_glyph_dec.sv | 22 ++
 rtl/seg_rx.sv | 182 ++++++++++++++++++
 tb/tb_seg_rx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: glyph table, FSM state type and digit indices.
// Glyph bit order is bit 0 = segment a ... bit 6 = segment g.
package seg_pkg;

    localparam int unsigned GLYPH_W    = 7;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;

    localparam logic [GLYPH_W-1:0] SEG_BLANK = 7'h00;

    // Indexed by nibble value; element 0 is the right-most entry
    localparam logic [15:0][GLYPH_W-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        LOCKED
    } seg_state_t;

    localparam logic [1:0] DIG_D1 = 2'd3;
    localparam logic [1:0] DIG_D2 = 2'd2;
    localparam logic [1:0] DIG_D3 = 2'd1;
    localparam logic [1:0] DIG_D4 = 2'd0;

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational seven-segment glyph decoder: pattern -> {legal, nibble}.
// Blank and any pattern outside the glyph table report illegal with nibble 0.
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [GLYPH_W-1:0] i_pattern,
    output logic               o_legal_c,
    output logic [NIB_W-1:0]   o_nibble_c
);

    always_comb begin
        o_legal_c  = 1'b0;
        o_nibble_c = '0;
        for (int unsigned n = 0; n < 16; n++) begin
            if (i_pattern == GLYPH_TABLE[n]) begin
                o_legal_c  = 1'b1;
                o_nibble_c = NIB_W'(n);
            end
        end
    end

endmodule

// File: rtl/seg_rx.sv
// Seven-segment display bus receiver: syncs the bus, locks stable patterns and rebuilds the 4-digit value.
// Optional SEG_RX_DP_EN: include seg[7] in the stability compare and capture it into dp.
module seg_rx
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned WINDOW_CYCLES = 65536
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [0:7]  seg,
    input  logic        d1,
    input  logic        d2,
    input  logic        d3,
    input  logic        d4,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic [3:0]  dp,
    output logic        update
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned SAMP_W = GLYPH_W + 1 + NUM_DIGITS;

    logic [0:7]           r_seg_s1;
    logic [0:7]           r_seg_s2;
    logic [3:0]           r_en_s1;
    logic [3:0]           r_en_s2;
    logic [SAMP_W-1:0]    r_prev;
    logic [CNT_W-1:0]     r_cnt;
    seg_state_t           r_state;
    logic [WIN_W-1:0]     r_win;
    logic [15:0]          r_value;
    logic [3:0]           r_valid;
    logic [3:0]           r_err;
    logic [3:0]           r_dp;
    logic [3:0]           r_seen;
    logic                 r_update;

    logic [GLYPH_W-1:0]   w_pat;
    logic                 w_dp_s;
    logic [SAMP_W-1:0]    w_sample;
    logic                 w_onehot;
    logic                 w_same;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_capture;
    logic [1:0]           w_idx;
    logic                 w_legal;
    logic [NIB_W-1:0]     w_nib;
    logic [3:0]           w_cap_vec;
    logic [15:0]          w_value_nx;
    logic [3:0]           w_err_nx;
    logic [3:0]           w_dp_nx;
    logic [3:0]           w_valid_cap;
    logic                 w_changed;
    logic                 w_wrap;

    // Two-flop synchronizers; enables idle high so nothing is selected out of reset
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
            r_en_s1  <= '1;
            r_en_s2  <= '1;
        end else begin
            r_seg_s1 <= seg;
            r_seg_s2 <= r_seg_s1;
            r_en_s1  <= {d1, d2, d3, d4};
            r_en_s2  <= r_en_s1;
        end
    end

    assign w_pat = {r_seg_s2[6], r_seg_s2[5], r_seg_s2[4], r_seg_s2[3],
                    r_seg_s2[2], r_seg_s2[1], r_seg_s2[0]};

`ifdef SEG_RX_DP_EN
    assign w_dp_s = r_seg_s2[7];
`else
    logic w_unused_dp;
    assign w_dp_s      = 1'b0;
    assign w_unused_dp = r_seg_s2[7];
`endif

    assign w_sample  = {w_pat, w_dp_s, r_en_s2};
    assign w_onehot  = $onehot(~r_en_s2);
    assign w_same    = (w_sample == r_prev);
    assign w_cnt_inc = (r_cnt == CNT_W'(STABLE_CYCLES)) ? r_cnt : r_cnt + CNT_W'(1);

    // Stability FSM: count consecutive identical samples while exactly one digit is enabled
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_prev  <= {SEG_BLANK, 1'b0, 4'hF};
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_prev <= w_sample;
            if (!w_onehot) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (!w_same) begin
                r_state <= SETTLING;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= w_cnt_inc;
                r_state <= (w_cnt_inc == CNT_W'(STABLE_CYCLES)) ? LOCKED : SETTLING;
            end
        end
    end

    assign w_capture = (r_state == LOCKED) && w_same;

    always_comb begin
        case (r_en_s2)
            4'b0111: w_idx = DIG_D1;
            4'b1011: w_idx = DIG_D2;
            4'b1101: w_idx = DIG_D3;
            default: w_idx = DIG_D4;
        endcase
    end

    seg_glyph_dec u_dec (
        .i_pattern  (w_pat),
        .o_legal_c  (w_legal),
        .o_nibble_c (w_nib)
    );

    assign w_cap_vec = w_capture ? (4'b0001 << w_idx) : 4'b0000;

    // Post-capture view of the digit registers; illegal glyphs keep the old nibble
    always_comb begin
        w_value_nx  = r_value;
        w_err_nx    = r_err;
        w_dp_nx     = r_dp;
        w_valid_cap = r_valid | w_cap_vec;
        if (w_capture) begin
            if (w_legal) begin
                w_value_nx[{w_idx, 2'b00} +: 4] = w_nib;
            end
            w_err_nx[w_idx] = ~w_legal;
            w_dp_nx[w_idx]  = w_dp_s;
        end
    end

    assign w_changed = w_capture &&
                       ({w_value_nx, w_err_nx, w_dp_nx, w_valid_cap} != {r_value, r_err, r_dp, r_valid});
    assign w_wrap    = (r_win == WIN_W'(WINDOW_CYCLES - 1));

    // Window bookkeeping and output registers; a capture on the wrap cycle keeps its digit valid
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_win    <= '0;
            r_value  <= '0;
            r_valid  <= '0;
            r_err    <= '0;
            r_dp     <= '0;
            r_seen   <= '0;
            r_update <= 1'b0;
        end else begin
            r_win    <= w_wrap ? '0 : r_win + WIN_W'(1);
            r_value  <= w_value_nx;
            r_err    <= w_err_nx;
            r_dp     <= w_dp_nx;
            r_update <= w_changed;
            if (w_wrap) begin
                r_valid <= r_seen | w_cap_vec;
                r_seen  <= w_cap_vec;
            end else begin
                r_valid <= w_valid_cap;
                r_seen  <= r_seen | w_cap_vec;
            end
        end
    end

    assign value       = r_value;
    assign digit_valid = r_valid;
    assign digit_err   = r_err;
    assign dp          = r_dp;
    assign update      = r_update;

endmodule

// File: tb/tb_seg_rx.sv
// Bench for seg_rx: directed scenarios plus randomized bus traffic, checked every cycle
// against a sample-history reference model.
module tb_seg_rx;

    localparam int unsigned S  = 4;
    localparam int unsigned W  = 256;
    localparam int unsigned HL = S + 4;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b0;
    logic [0:7]  seg    = '0;
    logic        d1 = 1'b1, d2 = 1'b1, d3 = 1'b1, d4 = 1'b1;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic [3:0]  dp;
    logic        update;

    seg_rx #(.STABLE_CYCLES(S), .WINDOW_CYCLES(W)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .seg         (seg),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .d4          (d4),
        .value       (value),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .dp          (dp),
        .update      (update)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    string GLYPHS [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [0:7] segs_of(input string s);
        logic [0:7] r;
        int k;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            k = int'(s[i]) - 97;
            r[k] = 1'b1;
        end
        return r;
    endfunction

    // Reference model: a capture happens when the last S+2 synchronized samples agree
    typedef struct packed {
        logic [0:7] s;
        logic [3:0] en;
    } samp_t;

    samp_t       hist[$];
    logic [15:0] m_value;
    logic [3:0]  m_valid, m_err, m_dp, m_seen;
    logic        m_update;
    int unsigned m_edge;
    logic        obs_up;

    function automatic samp_t cur_sample();
        samp_t x;
        x.s  = seg;
`ifndef SEG_RX_DP_EN
        x.s[7] = 1'b0;
`endif
        x.en = {d1, d2, d3, d4};
        return x;
    endfunction

    task automatic model_reset();
        m_value  = '0;
        m_valid  = '0;
        m_err    = '0;
        m_dp     = '0;
        m_seen   = '0;
        m_update = 1'b0;
        m_edge   = 0;
        hist.delete();
        for (int i = 0; i < int'(HL); i++) hist.push_back('{s: 8'h00, en: 4'hF});
    endtask

    task automatic model_edge();
        samp_t       h0;
        logic        cap;
        logic        legal;
        int          dig;
        logic [3:0]  nib;
        logic [3:0]  capbit;
        logic [0:7]  g;
        logic [15:0] ov;
        logic [3:0]  oe, od;
        m_edge++;
        hist.push_back(cur_sample());
        void'(hist.pop_front());
        h0  = hist[0];
        cap = ($countones(~h0.en) == 1);
        for (int i = 1; i <= int'(S) + 1; i++) if (hist[i] != h0) cap = 1'b0;
        capbit   = '0;
        m_update = 1'b0;
        if (cap) begin
            dig = 0;
            for (int i = 0; i < 4; i++) if (!h0.en[i]) dig = i;
            legal = 1'b0;
            nib   = '0;
            for (int n = 0; n < 16; n++) begin
                g = segs_of(GLYPHS[n]);
                if (g[0:6] == h0.s[0:6]) begin
                    legal = 1'b1;
                    nib   = 4'(n);
                end
            end
            ov = m_value;
            oe = m_err;
            od = m_dp;
            if (legal) m_value[dig*4 +: 4] = nib;
            m_err[dig]  = ~legal;
            m_dp[dig]   = h0.s[7];
            capbit[dig] = 1'b1;
            m_update = (m_value != ov) || (m_err != oe) || (m_dp != od) || ((capbit & ~m_valid) != 4'b0);
        end
        if (m_edge % W == 0) begin
            m_valid = m_seen | capbit;
            m_seen  = capbit;
        end else begin
            m_valid = m_valid | capbit;
            m_seen  = m_seen | capbit;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        obs_up = update;
        check("value", 32'(value), 32'(m_value));
        check("digit_valid", 32'(digit_valid), 32'(m_valid));
        check("digit_err", 32'(digit_err), 32'(m_err));
        check("dp", 32'(dp), 32'(m_dp));
        check("update", 32'(update), 32'(m_update));
    endtask

    task automatic drive(input logic [3:0] en, input logic [0:7] s);
        {d1, d2, d3, d4} = en;
        seg = s;
    endtask

    task automatic show(input logic [3:0] en, input logic [0:7] s, input int cycles, output int pulses);
        drive(en, s);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (obs_up) pulses++;
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before the next clock edge
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_value"}, 32'(value), 32'h0);
        check({tag, "_valid"}, 32'(digit_valid), 32'h0);
        check({tag, "_err"}, 32'(digit_err), 32'h0);
        check({tag, "_dp"}, 32'(dp), 32'h0);
        check({tag, "_update"}, 32'(update), 32'h0);
        model_reset();
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    initial begin
        int pulses, tmp, first_up, n_up;
        logic [0:7] s;
        logic [3:0] en;
        int r;

        model_reset();
        #2 rst = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_err", 32'(digit_err), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_update", 32'(update), 32'h0);
        rst = 1'b0;

        // Single digit: d1 shows 8
        drive(4'b0111, segs_of(GLYPHS[8]));
        first_up = -1;
        n_up = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (obs_up) begin
                n_up++;
                if (first_up < 0) first_up = c;
            end
        end
        check("sd_nib", 32'(value[15:12]), 32'h8);
        check("sd_valid", 32'(digit_valid), 32'h8);
        check("sd_pulses", 32'(n_up), 32'd1);
        check("sd_latency", 32'(first_up), 32'(S + 3));

        // Multiplex scan 1, A, 3, F
        show(4'b0111, segs_of(GLYPHS[1]), 20, tmp);
        show(4'b1011, segs_of(GLYPHS[10]), 20, tmp);
        show(4'b1101, segs_of(GLYPHS[3]), 20, tmp);
        show(4'b1110, segs_of(GLYPHS[15]), 20, tmp);
        check("mx_value", 32'(value), 32'h1A3F);
        check("mx_valid", 32'(digit_valid), 32'hF);
        check("mx_err", 32'(digit_err), 32'h0);

        // Illegal glyph on d2
        show(4'b1011, segs_of("ag"), 20, pulses);
        check("il_err", 32'(digit_err), 32'h4);
        check("il_nib", 32'(value[11:8]), 32'hA);
        check("il_pulses", 32'(pulses), 32'd1);

        // Two-cycle glitch while d3 is locked
        show(4'b1101, segs_of(GLYPHS[3]), 20, tmp);
        show(4'b1101, segs_of(GLYPHS[8]), 2, pulses);
        show(4'b1101, segs_of(GLYPHS[3]), 20, tmp);
        check("gl_pulses", 32'(pulses + tmp), 32'd0);
        check("gl_value", 32'(value), 32'h1A3F);

        // Window expiry with d2 left in error
        show(4'b0111, segs_of(GLYPHS[1]), 20, tmp);
        show(4'b1011, segs_of("ag"), 20, tmp);
        show(4'b1101, segs_of(GLYPHS[3]), 20, tmp);
        show(4'b1110, segs_of(GLYPHS[15]), 20, tmp);
        show(4'b0111, segs_of(GLYPHS[1]), 2 * W, tmp);
        check("we_valid", 32'(digit_valid), 32'h8);
        check("we_value", 32'(value), 32'h1A3F);
        check("we_err", 32'(digit_err), 32'h4);

        // Reset while settling, then d4 shows 5 with dp lit
        show(4'b1011, segs_of(GLYPHS[5]), 3, tmp);
        do_reset("rs");
        s = segs_of(GLYPHS[5]);
        s[7] = 1'b1;
        show(4'b1110, s, 12, pulses);
`ifdef SEG_RX_DP_EN
        check("dp_val", 32'(dp), 32'h1);
`else
        check("dp_val", 32'(dp), 32'h0);
`endif
        check("dp_valid", 32'(digit_valid), 32'h1);
        check("dp_nib", 32'(value[3:0]), 32'h5);
        check("dp_pulses", 32'(pulses), 32'd1);

        // Randomized bus traffic
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 8) en = ~(4'b0001 << $urandom_range(0, 3));
            else       en = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 7)      s = segs_of(GLYPHS[$urandom_range(0, 15)]);
            else if (r < 9) s = 8'($urandom);
            else            s = '0;
            s[7] = 1'($urandom);
            show(en, s, $urandom_range(1, 24), tmp);
            if (it == 150) do_reset("rr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
